// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx
// Description : Word-to-serial frame transmitter (start, data LSB first,
//               optional parity, stop), one frame bit per in_en tick.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              in_rst_n,
    input  logic              in_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              out_ready,
    output logic              out_serial,
    output logic              out_busy,
    output logic              out_done
);

    localparam int                 c_cnt_w = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_W);
    localparam logic               c_odd   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shreg;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_parity;

    always_ff @(posedge clk) begin
        if (!in_rst_n) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_parity   <= 1'b0;
            out_serial <= 1'b1;
            out_ready  <= 1'b1;
            out_busy   <= 1'b0;
            out_done   <= 1'b0;
        end else begin
            out_done <= 1'b0;
            case (r_state)
                // in_en is deliberately ignored here so the start bit always
                // begins on a full in_en interval.
                ST_IDLE: begin
                    if (in_valid && out_ready) begin
                        r_shreg   <= in_data;
                        r_parity  <= (^in_data) ^ c_odd;
                        out_ready <= 1'b0;
                        out_busy  <= 1'b1;
                        r_state   <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (in_en) begin
                        out_serial <= 1'b0;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (in_en) begin
                        out_serial <= r_shreg[0];
                        r_shreg    <= {1'b0, r_shreg[DATA_W-1:1]};
                        r_cnt      <= c_cnt_w'(1);
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (in_en) begin
                        if (r_cnt < c_last) begin
                            out_serial <= r_shreg[0];
                            r_shreg    <= {1'b0, r_shreg[DATA_W-1:1]};
                            r_cnt      <= r_cnt + c_cnt_w'(1);
                        end else if (PARITY_EN != 0) begin
                            out_serial <= r_parity;
                            r_state    <= ST_PARITY;
                        end else begin
                            out_serial <= 1'b1;
                            r_state    <= ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (in_en) begin
                        out_serial <= 1'b1;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (in_en) begin
                        r_cnt     <= '0;
                        out_ready <= 1'b1;
                        out_busy  <= 1'b0;
                        out_done  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_tx
// Description : Directed bench for serial_frame_tx (default, odd-parity and
//               no-parity instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] data;
    logic       valid_def, valid_odd, valid_np;

    logic ser0, rdy0, bsy0, dn0;
    logic ser1, rdy1, bsy1, dn1;
    logic ser2, rdy2, bsy2, dn2;

    int n_pass  = 0;
    int n_total = 0;

    serial_frame_tx dut_def (
        .clk(clk), .in_rst_n(rst_n), .in_en(en), .in_data(data), .in_valid(valid_def),
        .out_ready(rdy0), .out_serial(ser0), .out_busy(bsy0), .out_done(dn0)
    );
    serial_frame_tx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .in_rst_n(rst_n), .in_en(en), .in_data(data), .in_valid(valid_odd),
        .out_ready(rdy1), .out_serial(ser1), .out_busy(bsy1), .out_done(dn1)
    );
    serial_frame_tx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
        .clk(clk), .in_rst_n(rst_n), .in_en(en), .in_data(data), .in_valid(valid_np),
        .out_ready(rdy2), .out_serial(ser2), .out_busy(bsy2), .out_done(dn2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output nibble is {serial, ready, busy, done}.
    function automatic logic [3:0] outs(input int which);
        case (which)
            1:       return {ser1, rdy1, bsy1, dn1};
            2:       return {ser2, rdy2, bsy2, dn2};
            default: return {ser0, rdy0, bsy0, dn0};
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Accept a word with in_en=1 (must be ignored), then run nbits edges
    // comparing each serial bit against frame[i], then done and idle.
    task automatic run_frame(input int which, input logic [7:0] d, input int nbits,
                             input logic [15:0] frame, input string tag);
        logic [3:0] o;
        data = d;
        en   = 1'b1;
        valid_def = (which == 0);
        valid_odd = (which == 1);
        valid_np  = (which == 2);
        edge_step();
        valid_def = 1'b0; valid_odd = 1'b0; valid_np = 1'b0;
        data = ~d;
        chk($sformatf("%s_accept", tag), 16'(outs(which)), 16'b1010);
        for (int i = 0; i < nbits; i++) begin
            edge_step();
            o = outs(which);
            chk($sformatf("%s_bit%0d", tag, i), 16'({o[3], o[1]}), 16'({frame[i], 1'b1}));
        end
        edge_step();
        chk($sformatf("%s_done", tag), 16'(outs(which)), 16'b1101);
        edge_step();
        chk($sformatf("%s_idle", tag), 16'(outs(which)), 16'b1100);
    endtask

    typedef struct packed {
        logic       rst_n;
        logic       en;
        logic       valid;
        logic [7:0] data;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[19];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [15:0] fr;
        logic [3:0]  o;
        rst_n = 1'b0; en = 1'b0; data = 8'h00;
        valid_def = 1'b0; valid_odd = 1'b0; valid_np = 1'b0;

        // Reset with stimulus, then basic 8'hA5 frame (even parity 0).
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 4'b1100};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 4'b1100};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 4'b1100};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 4'b1100};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 4'b1100};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 4'b1010};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b0010};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b1010};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b0010};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b1010};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b0010};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b0010};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b1010};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b0010};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b1010};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b0010};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b1010};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b1101};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'b1100};

        for (int i = 0; i < 19; i++) begin
            rst_n     = tbl[i].rst_n;
            en        = tbl[i].en;
            valid_def = tbl[i].valid;
            data      = tbl[i].data;
            edge_step();
            chk($sformatf("vec%0d", i), 16'(outs(0)), 16'(tbl[i].exp));
        end
        valid_def = 1'b0;

        // Slow enable: 8'h81, in_en 1-in-4, 20-clk freeze during data bit d3.
        fr = 16'h0502;
        en = 1'b0; data = 8'h81; valid_def = 1'b1;
        edge_step();
        valid_def = 1'b0;
        chk("slow_accept", 16'(outs(0)), 16'b1010);
        for (int i = 0; i < 11; i++) begin
            for (int s = 0; s < 4; s++) begin
                en = (s == 0);
                edge_step();
                o = outs(0);
                chk($sformatf("slow_b%0d_s%0d", i, s), 16'(o), 16'({fr[i], 3'b010}));
            end
            if (i == 4) begin
                en = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    edge_step();
                    chk($sformatf("freeze%0d", k), 16'(outs(0)), 16'({fr[i], 3'b010}));
                end
            end
        end
        en = 1'b1;
        edge_step();
        chk("slow_done", 16'(outs(0)), 16'b1101);
        en = 1'b0;
        edge_step();
        chk("slow_idle", 16'(outs(0)), 16'b1100);

        // Parity variants.
        run_frame(1, 8'h00, 11, 16'h0600, "odd00");
        run_frame(2, 8'hFF, 10, 16'h03FE, "nopar");
        chk("np_no_parity_slot", 16'(outs(2)), 16'b1100);

        // Back-to-back with in_valid held and data switched mid-frame.
        fr = 16'h0478;
        en = 1'b1; data = 8'h3C; valid_def = 1'b1;
        edge_step();
        chk("b2b_acc1", 16'(outs(0)), 16'b1010);
        for (int i = 0; i < 11; i++) begin
            if (i == 5) data = 8'hC3;
            edge_step();
            o = outs(0);
            chk($sformatf("b2b1_bit%0d", i), 16'(o), 16'({fr[i], 3'b010}));
        end
        edge_step();
        chk("b2b_done1", 16'(outs(0)), 16'b1101);
        edge_step();
        chk("b2b_acc2", 16'(outs(0)), 16'b1010);
        valid_def = 1'b0;
        fr = 16'h0586;
        for (int i = 0; i < 11; i++) begin
            edge_step();
            o = outs(0);
            chk($sformatf("b2b2_bit%0d", i), 16'(o), 16'({fr[i], 3'b010}));
        end
        edge_step();
        chk("b2b_done2", 16'(outs(0)), 16'b1101);
        edge_step();
        chk("b2b_idle", 16'(outs(0)), 16'b1100);

        // Reset during data bit d3 (serial low), no done pulse afterwards.
        en = 1'b1; data = 8'h00; valid_def = 1'b1;
        edge_step();
        valid_def = 1'b0;
        for (int i = 0; i < 5; i++) edge_step();
        chk("mid_d3", 16'(outs(0)), 16'b0010);
        rst_n = 1'b0;
        edge_step();
        chk("mid_rst", 16'(outs(0)), 16'b1100);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            edge_step();
            chk($sformatf("mid_after%0d", k), 16'(outs(0)), 16'b1100);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
